// File: rtl/sap_core_param.sv
// Parametrised accumulator processor core: FETCH/DECODE/EXEC micro-steps gated by i_step,
// conditional branches on carry/zero, and a HALT state left only through reset.
module sap_core_param #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4,
   parameter int OPC_W  = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_step,
   input  logic [DATA_W-1:0]         i_data_in,
   input  logic [OPC_W+DATA_W-1:0]   i_rom_data,
   output logic [ADDR_W-1:0]         o_pc,
   output logic [DATA_W-1:0]         o_acc_a,
   output logic [DATA_W-1:0]         o_acc_b,
   output logic [DATA_W-1:0]         o_bus,
   output logic [DATA_W-1:0]         o_out,
   output logic                      o_carry,
   output logic                      o_zero,
   output logic                      o_halted,
   output logic [1:0]                o_state
);

   localparam int IR_W = OPC_W + DATA_W;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      HALT   = 2'd3
   } state_t;

   localparam logic [OPC_W-1:0] OP_LDA  = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_LDB  = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_JC   = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(9);
   localparam logic [OPC_W-1:0] OP_MOVB = OPC_W'(10);
   localparam logic [OPC_W-1:0] OP_HLT  = '1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, out_q, out_d;
   logic [IR_W-1:0]     ir_q, ir_d;
   logic                c_q, c_d, z_q, z_d;
   logic [DATA_W-1:0]   bus;

   logic [OPC_W-1:0]    opc;
   logic [DATA_W-1:0]   imm;
   logic [ADDR_W-1:0]   target;
   logic [DATA_W:0]     add_res;

   assign opc     = ir_q[IR_W-1:DATA_W];
   assign imm     = ir_q[DATA_W-1:0];
   assign target  = imm[ADDR_W-1:0];
   assign add_res = {1'b0, a_q} + {1'b0, b_q};

   // NOTE: state is written with non-blocking assignments only; all next values come from the comb blocks.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= FETCH;
         pc_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ir_q    <= '0;
         out_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
      end else if (i_step) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ir_q    <= ir_d;
         out_q   <= out_d;
         c_q     <= c_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE:  state_d = EXEC;
         EXEC:    state_d = (opc == OP_HLT) ? HALT : FETCH;
         default: state_d = HALT;
      endcase
   end

   // Datapath: bus carries the operand except in EXEC, where it carries the written value.
   always_comb begin
      logic [DATA_W-1:0] tgt_ext;
      tgt_ext = '0;
      tgt_ext[ADDR_W-1:0] = target;
      pc_d  = pc_q;
      a_d   = a_q;
      b_d   = b_q;
      ir_d  = ir_q;
      out_d = out_q;
      c_d   = c_q;
      z_d   = z_q;
      bus   = imm;
      if (state_q == FETCH) begin
         ir_d = i_rom_data;
         pc_d = pc_q + ADDR_W'(1);
      end else if (state_q == EXEC) begin
         case (opc)
            OP_LDA: begin
               a_d = imm;
               z_d = (a_d == '0);
               bus = a_d;
            end
            OP_LDB: begin
               b_d = imm;
               bus = b_d;
            end
            OP_ADD: begin
               {c_d, a_d} = add_res;
               z_d = (a_d == '0);
               bus = a_d;
            end
            OP_SUB: begin
               a_d = a_q - b_q;
               c_d = (a_q >= b_q);
               z_d = (a_d == '0);
               bus = a_d;
            end
            OP_IN: begin
               a_d = i_data_in;
               z_d = (a_d == '0);
               bus = a_d;
            end
            OP_OUT: begin
               out_d = a_q;
               bus   = a_q;
            end
            OP_JMP: begin
               pc_d = target;
               bus  = tgt_ext;
            end
            OP_JC: begin
               if (c_q) pc_d = target;
               bus = tgt_ext;
            end
            OP_JZ: begin
               if (z_q) pc_d = target;
               bus = tgt_ext;
            end
            OP_MOVB: begin
               b_d = a_q;
               bus = a_q;
            end
            default: ;
         endcase
      end
   end

   assign o_pc     = pc_q;
   assign o_acc_a  = a_q;
   assign o_acc_b  = b_q;
   assign o_bus    = bus;
   assign o_out    = out_q;
   assign o_carry  = c_q;
   assign o_zero   = z_q;
   assign o_halted = (state_q == HALT);
   assign o_state  = state_q;

endmodule

// File: tb/tb_sap_core_param.sv
// Self-checking bench for sap_core_param: directed programs plus random programs and step
// patterns, compared every cycle against an instruction-level reference model.
module tb_sap_core_param;

   logic       clk = 1'b0;
   logic       reset, step;
   logic [3:0] din;
   logic [7:0] rom_data;
   logic [3:0] pc, acc_a, acc_b, bus, out;
   logic       carry, zero, halted;
   logic [1:0] state;

   logic [7:0] rom [16];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: phase 0/1/2 = fetch/decode/execute, 3 = halted.
   int m_pc, m_a, m_b, m_ir, m_out, m_c, m_z, m_phase;

   sap_core_param #(.DATA_W(4), .ADDR_W(4), .OPC_W(4)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_step     (step),
      .i_data_in  (din),
      .i_rom_data (rom_data),
      .o_pc       (pc),
      .o_acc_a    (acc_a),
      .o_acc_b    (acc_b),
      .o_bus      (bus),
      .o_out      (out),
      .o_carry    (carry),
      .o_zero     (zero),
      .o_halted   (halted),
      .o_state    (state)
   );

   always #5 clk = ~clk;
   assign rom_data = rom[pc];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_bus();
      int op, imm;
      op  = m_ir / 16;
      imm = m_ir % 16;
      if (m_phase != 2) return imm;
      case (op)
         1, 2:    return imm;
         3:       return (m_a + m_b) % 16;
         4:       return (m_a - m_b + 16) % 16;
         5:       return int'(din);
         6, 10:   return m_a;
         default: return imm;
      endcase
   endfunction

   task automatic model_edge();
      int op, imm;
      if (reset) begin
         m_pc = 0; m_a = 0; m_b = 0; m_ir = 0; m_out = 0; m_c = 0; m_z = 0; m_phase = 0;
         return;
      end
      if (!step || m_phase == 3) return;
      case (m_phase)
         0: begin
            m_ir = int'(rom[m_pc]);
            m_pc = (m_pc + 1) % 16;
            m_phase = 1;
         end
         1: m_phase = 2;
         default: begin
            op  = m_ir / 16;
            imm = m_ir % 16;
            m_phase = 0;
            case (op)
               1:  begin m_a = imm; m_z = (m_a == 0); end
               2:  m_b = imm;
               3:  begin m_c = (m_a + m_b > 15); m_a = (m_a + m_b) % 16; m_z = (m_a == 0); end
               4:  begin m_c = (m_a >= m_b); m_a = (m_a - m_b + 16) % 16; m_z = (m_a == 0); end
               5:  begin m_a = int'(din); m_z = (m_a == 0); end
               6:  m_out = m_a;
               7:  m_pc = imm;
               8:  if (m_c == 1) m_pc = imm;
               9:  if (m_z == 1) m_pc = imm;
               10: m_b = m_a;
               15: m_phase = 3;
               default: ;
            endcase
         end
      endcase
   endtask

   task automatic compare_all();
      check("pc",     pc,     m_pc);
      check("acc_a",  acc_a,  m_a);
      check("acc_b",  acc_b,  m_b);
      check("out",    out,    m_out);
      check("carry",  carry,  m_c);
      check("zero",   zero,   m_z);
      check("state",  state,  m_phase);
      check("halted", halted, (m_phase == 3));
      check("bus",    bus,    exp_bus());
   endtask

   // One clock: model follows the inputs seen at the edge, outputs compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run_steps(input int n);
      step = 1'b1;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic load_rom(input logic [7:0] p0, p1, p2, p3, p4);
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3; rom[4] = p4;
   endtask

   initial begin
      reset = 1'b1;
      step  = 1'b0;
      din   = 4'd0;
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      m_pc = 0; m_a = 0; m_b = 0; m_ir = 0; m_out = 0; m_c = 0; m_z = 0; m_phase = 0;
      @(negedge clk);
      tick();
      reset = 1'b0;

      // Reset mid-EXEC, then hold with step low.
      load_rom(8'h17, 8'h25, 8'h30, 8'h60, 8'hF0);
      do_reset();
      run_steps(5);
      check("mid_exec_state", state, 2);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_state", state, 0);
      check("rst_a", acc_a, 0);
      check("rst_b", acc_b, 0);
      check("rst_pc", pc, 0);
      step = 1'b0;
      repeat (10) tick();
      check("hold_pc", pc, 0);

      // Add and output, then halt.
      run_steps(15);
      check("s2_out", out, 12);
      check("s2_carry", carry, 0);
      check("s2_zero", zero, 0);
      check("s2_halted", halted, 1);
      run_steps(6);
      check("s2_halt_out", out, 12);
      check("s2_halt_pc", pc, 5);

      // Carry-driven branch, taken and not taken.
      load_rom(8'h19, 8'h28, 8'h30, 8'h86, 8'h00);
      do_reset();
      run_steps(12);
      check("s3_a", acc_a, 1);
      check("s3_c", carry, 1);
      check("s3_pc", pc, 6);
      load_rom(8'h19, 8'h22, 8'h30, 8'h86, 8'h00);
      do_reset();
      run_steps(12);
      check("s3b_a", acc_a, 11);
      check("s3b_c", carry, 0);
      check("s3b_pc", pc, 4);

      // Zero-driven loop.
      load_rom(8'h13, 8'h23, 8'h40, 8'h90, 8'h00);
      do_reset();
      run_steps(12);
      check("s4_a", acc_a, 0);
      check("s4_z", zero, 1);
      check("s4_c", carry, 1);
      check("s4_pc", pc, 0);
      run_steps(12);
      check("s4_loop_pc", pc, 0);
      check("s4_loop_z", zero, 1);

      // PC wrap on an all-NOP program.
      load_rom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      do_reset();
      run_steps(45);
      check("s5_pc15", pc, 15);
      run_steps(3);
      check("s5_wrap", pc, 0);
      check("s5_a", acc_a, 0);

      // Input, move, add to zero with carry, output.
      load_rom(8'h50, 8'hA0, 8'h30, 8'h60, 8'h00);
      din = 4'd8;
      do_reset();
      run_steps(2);
      check("s6_in_bus", bus, 8);
      run_steps(10);
      check("s6_b", acc_b, 8);
      check("s6_a", acc_a, 0);
      check("s6_c", carry, 1);
      check("s6_z", zero, 1);
      check("s6_out", out, 0);

      // Random programs, step patterns, inputs and occasional resets.
      for (int p = 0; p < 25; p++) begin
         for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
         do_reset();
         for (int c = 0; c < 200; c++) begin
            step  = ($urandom_range(0, 3) != 0);
            din   = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 99) == 0);
            tick();
         end
         reset = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
